// File: rtl/rvfpm_spec_pkg.sv
// Package: rvfpm_spec_pkg
// Shared types for the speculative-id tracker.
//   spec_state_e : lifecycle of one tracked XIF instruction id
//   spec_entry_t : stored state plus id (id held at SPEC_ID_MAX_W, upper bits stay zero)
//   ERR_*        : bit positions inside the tracker's err pulse vector
package rvfpm_spec_pkg;

    typedef enum logic [1:0] {
        FREE      = 2'd0,
        SPEC      = 2'd1,
        COMMITTED = 2'd2,
        KILLED    = 2'd3
    } spec_state_e;

    // Widest X_ID_WIDTH the entry storage supports.
    localparam int unsigned SPEC_ID_MAX_W = 16;

    typedef struct packed {
        spec_state_e               state;
        logic [SPEC_ID_MAX_W-1:0]  id;
    } spec_entry_t;

    localparam int unsigned ERR_DUP        = 0;
    localparam int unsigned ERR_UNK_COMMIT = 1;
    localparam int unsigned ERR_RETIRE     = 2;

endpackage

// File: rtl/rvfpm_spec_entry.sv
// Module: rvfpm_spec_entry
// One tracker slot: state FSM (FREE -> SPEC -> COMMITTED/KILLED -> FREE) and id comparators.
// The parent decodes all strobes; this block only applies them with priority
// alloc > retire > commit > kill-younger.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   alloc_en_i             take alloc_id_i into this slot with state alloc_state_i
//   commit_en_i            move SPEC to COMMITTED (commit_kill_i=0) or KILLED (=1)
//   kill_en_i              move to KILLED because an older entry was killed
//   retire_en_i            free the slot
//   commit_id_i/retire_id_i/alloc_id_i/lu_id_i  ids to compare against the stored id
//   state_o                current state
//   *_match_o              slot is live and its id equals the corresponding id
module rvfpm_spec_entry
    import rvfpm_spec_pkg::*;
#(
    parameter int unsigned X_ID_WIDTH = 4,
    parameter int unsigned NUM_LOOKUP = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             alloc_en_i,
    input  spec_state_e                      alloc_state_i,
    input  logic [X_ID_WIDTH-1:0]            alloc_id_i,
    input  logic                             commit_en_i,
    input  logic                             commit_kill_i,
    input  logic                             kill_en_i,
    input  logic                             retire_en_i,
    input  logic [X_ID_WIDTH-1:0]            commit_id_i,
    input  logic [X_ID_WIDTH-1:0]            retire_id_i,
    input  logic [NUM_LOOKUP*X_ID_WIDTH-1:0] lu_id_i,
    output spec_state_e                      state_o,
    output logic                             alloc_match_o,
    output logic                             commit_match_o,
    output logic                             retire_match_o,
    output logic [NUM_LOOKUP-1:0]            lu_match_o
);

    spec_entry_t entry_d, entry_q;
    logic        live;

    function automatic logic [SPEC_ID_MAX_W-1:0] to_id_w(input logic [X_ID_WIDTH-1:0] id);
        return SPEC_ID_MAX_W'(id);
    endfunction

    always_comb begin
        entry_d = entry_q;
        if (alloc_en_i) begin
            entry_d.state = alloc_state_i;
            entry_d.id    = to_id_w(alloc_id_i);
        end else if (retire_en_i) begin
            entry_d.state = FREE;
        end else if (commit_en_i) begin
            entry_d.state = commit_kill_i ? KILLED : COMMITTED;
        end else if (kill_en_i) begin
            entry_d.state = KILLED;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign live           = (entry_q.state != FREE);
    assign state_o        = entry_q.state;
    assign alloc_match_o  = live && (entry_q.id == to_id_w(alloc_id_i));
    assign commit_match_o = live && (entry_q.id == to_id_w(commit_id_i));
    assign retire_match_o = live && (entry_q.id == to_id_w(retire_id_i));

    for (genvar k = 0; k < NUM_LOOKUP; k++) begin : g_lu
        assign lu_match_o[k] = live &&
            (entry_q.id == to_id_w(lu_id_i[k*X_ID_WIDTH +: X_ID_WIDTH]));
    end

endmodule

// File: rtl/rvfpm_spec_tracker.sv
// Module: rvfpm_spec_tracker
// Tracks XIF instructions accepted by the FPU but not yet committed/killed and retired.
// Ids are recorded on alloc, updated on commit/kill and released on retire; NUM_LOOKUP
// ports report whether an id is live and whether it is committed or killed.
// Ports:
//   ck, rst                   clock, asynchronous active-low reset
//   alloc_valid/alloc_id      record an accepted issue; alloc_ready = table not full
//   commit_valid/commit_id/commit_kill   XIF commit handshake (kill=1 kills)
//   retire_valid/retire_id    free an entry
//   lu_id                     lookup ids, port k at [k*X_ID_WIDTH +: X_ID_WIDTH]
//   lu_hit/lu_committed/lu_killed        per-port lookup results (combinational)
//   count/empty               registered number of live entries
//   err                       1-cycle pulses: dup alloc, unknown commit, bad retire
// Configuration:
//   RVFPM_SPEC_KILL_YOUNGER_EN  when defined, a kill also kills every younger SPEC entry
//                               (tracked with a DEPTH x DEPTH age matrix).
module rvfpm_spec_tracker
    import rvfpm_spec_pkg::*;
#(
    parameter int unsigned X_ID_WIDTH = 4,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned NUM_LOOKUP = 2
) (
    input  logic                             ck,
    input  logic                             rst,
    input  logic                             alloc_valid,
    input  logic [X_ID_WIDTH-1:0]            alloc_id,
    output logic                             alloc_ready,
    input  logic                             commit_valid,
    input  logic [X_ID_WIDTH-1:0]            commit_id,
    input  logic                             commit_kill,
    input  logic                             retire_valid,
    input  logic [X_ID_WIDTH-1:0]            retire_id,
    input  logic [NUM_LOOKUP*X_ID_WIDTH-1:0] lu_id,
    output logic [NUM_LOOKUP-1:0]            lu_hit,
    output logic [NUM_LOOKUP-1:0]            lu_committed,
    output logic [NUM_LOOKUP-1:0]            lu_killed,
    output logic [$clog2(DEPTH+1)-1:0]       count,
    output logic                             empty,
    output logic [2:0]                       err
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    spec_state_e [DEPTH-1:0]                  state;
    logic [DEPTH-1:0]                         alloc_match, commit_match, retire_match;
    logic [DEPTH-1:0][NUM_LOOKUP-1:0]         lu_match;
    logic [DEPTH-1:0]                         alloc_en, commit_en, retire_en, kill_en;
    spec_state_e                              alloc_state;
    logic [IDX_W-1:0]                         free_idx;
    logic                                     dup, alloc_fire, commit_on_alloc, same_id;
    logic [CNT_W-1:0]                         count_d, count_q;
    logic                                     empty_d, empty_q;
    logic [2:0]                               err_d, err_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        rvfpm_spec_entry #(
            .X_ID_WIDTH (X_ID_WIDTH),
            .NUM_LOOKUP (NUM_LOOKUP)
        ) u_entry (
            .clk_i          (ck),
            .rst_ni         (rst),
            .alloc_en_i     (alloc_en[i]),
            .alloc_state_i  (alloc_state),
            .alloc_id_i     (alloc_id),
            .commit_en_i    (commit_en[i]),
            .commit_kill_i  (commit_kill),
            .kill_en_i      (kill_en[i]),
            .retire_en_i    (retire_en[i]),
            .commit_id_i    (commit_id),
            .retire_id_i    (retire_id),
            .lu_id_i        (lu_id),
            .state_o        (state[i]),
            .alloc_match_o  (alloc_match[i]),
            .commit_match_o (commit_match[i]),
            .retire_match_o (retire_match[i]),
            .lu_match_o     (lu_match[i])
        );
    end

    // Fullness comes from the registered count only; a same-cycle retire does not help.
    assign alloc_ready = (count_q != CNT_W'(DEPTH));

    // Lowest-index FREE slot; only consulted when alloc_ready guarantees one exists.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (state[i] == FREE) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        dup             = alloc_valid && (|alloc_match);
        alloc_fire      = alloc_valid && alloc_ready && !dup;
        // A commit for an id that is being allocated right now lands directly in the final state.
        commit_on_alloc = commit_valid && !(|commit_match) && alloc_fire &&
                          (alloc_id == commit_id);
        alloc_state     = commit_on_alloc ? (commit_kill ? KILLED : COMMITTED) : SPEC;
        same_id         = commit_valid && (commit_id == retire_id);
        for (int i = 0; i < DEPTH; i++) begin
            alloc_en[i]  = alloc_fire && (free_idx == IDX_W'(i));
            commit_en[i] = commit_valid && commit_match[i] && (state[i] == SPEC);
            // A SPEC entry may only retire together with its own commit.
            retire_en[i] = retire_valid && retire_match[i] && ((state[i] != SPEC) || same_id);
        end
        err_d                 = '0;
        err_d[ERR_DUP]        = dup;
        err_d[ERR_UNK_COMMIT] = commit_valid && !(|commit_en) && !commit_on_alloc;
        err_d[ERR_RETIRE]     = retire_valid && !(|retire_en);
    end

`ifdef RVFPM_SPEC_KILL_YOUNGER_EN
    // age_q[i][j] set: entry i was allocated before entry j.
    logic [DEPTH-1:0][DEPTH-1:0] age_d, age_q;

    always_comb begin
        age_d = age_q;
        for (int s = 0; s < DEPTH; s++) begin
            if (alloc_en[s]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    age_d[i][s] = (state[i] != FREE);
                end
                age_d[s] = '0;
            end
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    always_comb begin
        kill_en = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (commit_en[k] && commit_kill) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (age_q[k][j] && (state[j] == SPEC)) begin
                        kill_en[j] = 1'b1;
                    end
                end
            end
        end
    end
`else
    assign kill_en = '0;
`endif

    // At most one entry retires and one allocates per cycle.
    always_comb begin
        count_d = count_q;
        if (alloc_fire && !(|retire_en)) begin
            count_d = count_q + CNT_W'(1);
        end else if (!alloc_fire && (|retire_en)) begin
            count_d = count_q - CNT_W'(1);
        end
        empty_d = (count_d == '0);
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            empty_q <= 1'b1;
            err_q   <= '0;
        end else begin
            count_q <= count_d;
            empty_q <= empty_d;
            err_q   <= err_d;
        end
    end

    assign count = count_q;
    assign empty = empty_q;
    assign err   = err_q;

    always_comb begin
        lu_hit       = '0;
        lu_committed = '0;
        lu_killed    = '0;
        for (int k = 0; k < NUM_LOOKUP; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                lu_hit[k]       = lu_hit[k] | lu_match[i][k];
                lu_committed[k] = lu_committed[k] | (lu_match[i][k] && (state[i] == COMMITTED));
                lu_killed[k]    = lu_killed[k] | (lu_match[i][k] && (state[i] == KILLED));
            end
        end
    end

endmodule

// File: tb/tb_rvfpm_spec_tracker.sv
// Bench for rvfpm_spec_tracker: directed scenarios then random traffic, all checked by a
// scoreboard fed from an age-ordered list model of the live ids.
module tb_rvfpm_spec_tracker;

    localparam int DEPTH = 8;
    localparam int ST_SPEC = 1, ST_COM = 2, ST_KILL = 3;

    logic       ck, rst;
    logic       alloc_valid, commit_valid, commit_kill, retire_valid;
    logic [3:0] alloc_id, commit_id, retire_id;
    logic [7:0] lu_id;
    logic       alloc_ready, empty;
    logic [1:0] lu_hit, lu_committed, lu_killed;
    logic [3:0] count;
    logic [2:0] err;

    rvfpm_spec_tracker #(
        .X_ID_WIDTH (4),
        .DEPTH      (DEPTH),
        .NUM_LOOKUP (2)
    ) dut (
        .ck           (ck),
        .rst          (rst),
        .alloc_valid  (alloc_valid),
        .alloc_id     (alloc_id),
        .alloc_ready  (alloc_ready),
        .commit_valid (commit_valid),
        .commit_id    (commit_id),
        .commit_kill  (commit_kill),
        .retire_valid (retire_valid),
        .retire_id    (retire_id),
        .lu_id        (lu_id),
        .lu_hit       (lu_hit),
        .lu_committed (lu_committed),
        .lu_killed    (lu_killed),
        .count        (count),
        .empty        (empty),
        .err          (err)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    typedef struct packed {
        logic [3:0] count;
        logic       empty;
        logic       ready;
        logic [2:0] err;
        logic [1:0] hit;
        logic [1:0] com;
        logic [1:0] kil;
    } exp_t;

    typedef struct {
        logic [3:0] id;
        int         st;
    } ent_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    ent_t       mq[$];     // live ids, oldest first
    logic [2:0] m_err;
    int         n_vec = 0;
    int         n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int find(input logic [3:0] id);
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].id == id) return i;
        end
        return -1;
    endfunction

    // Monitor: outputs are presented every cycle; compare against the oldest expectation.
    always @(negedge ck) begin
        if (rst && exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("count", 32'(count), 32'(mon_e.count));
            check("empty", 32'(empty), 32'(mon_e.empty));
            check("alloc_ready", 32'(alloc_ready), 32'(mon_e.ready));
            check("err", 32'(err), 32'(mon_e.err));
            check("lu_hit", 32'(lu_hit), 32'(mon_e.hit));
            check("lu_state", 32'({lu_committed, lu_killed}), 32'({mon_e.com, mon_e.kil}));
        end
    end

    // Drive one cycle of inputs, push the expected outputs for this cycle, advance the model.
    task automatic step(input logic av, input logic [3:0] aid, input logic cv,
                        input logic [3:0] cid, input logic ckl, input logic rv,
                        input logic [3:0] rid, input logic [3:0] l0, input logic [3:0] l1);
        exp_t       e;
        ent_t       t;
        int         ai, ci, ri, li;
        bit         take, e1, e2, do_commit, rfree;
        int         newst;
        logic [3:0] lus [2];
        @(posedge ck);
        #1;
        alloc_valid  = av;  alloc_id  = aid;
        commit_valid = cv;  commit_id = cid; commit_kill = ckl;
        retire_valid = rv;  retire_id = rid;
        lu_id        = {l1, l0};
        lus[0] = l0;
        lus[1] = l1;
        e.count = 4'(mq.size());
        e.empty = (mq.size() == 0);
        e.ready = (mq.size() < DEPTH);
        e.err   = m_err;
        for (int k = 0; k < 2; k++) begin
            li       = find(lus[k]);
            e.hit[k] = (li >= 0);
            e.com[k] = (li >= 0) && (mq[li].st == ST_COM);
            e.kil[k] = (li >= 0) && (mq[li].st == ST_KILL);
        end
        exp_q.push_back(e);
        // Decisions on the state before this edge.
        ai = find(aid); ci = find(cid); ri = find(rid);
        take = av && (mq.size() < DEPTH) && (ai < 0);
        e1 = 0; e2 = 0; do_commit = 0; rfree = 0; newst = ST_SPEC;
        if (cv) begin
            if (ci >= 0) begin
                if (mq[ci].st == ST_SPEC) do_commit = 1;
                else e1 = 1;
            end else if (take && aid == cid) begin
                newst = ckl ? ST_KILL : ST_COM;
            end else begin
                e1 = 1;
            end
        end
        if (rv) begin
            if (ri >= 0 && (mq[ri].st != ST_SPEC || (cv && cid == rid))) rfree = 1;
            else e2 = 1;
        end
        if (do_commit) begin
            t = mq[ci];
            t.st = ckl ? ST_KILL : ST_COM;
            mq[ci] = t;
`ifdef RVFPM_SPEC_KILL_YOUNGER_EN
            if (ckl) begin
                for (int j = ci + 1; j < mq.size(); j++) begin
                    if (mq[j].st == ST_SPEC) begin
                        t = mq[j];
                        t.st = ST_KILL;
                        mq[j] = t;
                    end
                end
            end
`endif
        end
        if (rfree) mq.delete(ri);
        if (take) begin
            t.id = aid;
            t.st = newst;
            mq.push_back(t);
        end
        m_err = {e2, e1, av && (ai >= 0)};
    endtask

    task automatic idle(input logic [3:0] l0, input logic [3:0] l1);
        step(0, 0, 0, 0, 0, 0, 0, l0, l1);
    endtask

    // Assert reset mid-cycle with an alloc pending; outputs must clear without an edge.
    task automatic reset_mid_cycle();
        @(posedge ck);
        #1;
        alloc_valid = 1; alloc_id = 4'd15;
        commit_valid = 0; retire_valid = 0;
        lu_id = (mq.size() >= 2) ? {mq[1].id, mq[0].id} : 8'h00;
        #2 rst = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_lu_hit", 32'(lu_hit), 32'd0);
        check("rst_ready", 32'(alloc_ready), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        alloc_valid = 0;
        mq.delete();
        m_err = '0;
        @(posedge ck);
        #3 rst = 1'b1;
    endtask

    function automatic logic [3:0] pick_id(input int pct_live);
        if (mq.size() > 0 && $urandom_range(0, 99) < pct_live)
            return mq[$urandom_range(0, mq.size() - 1)].id;
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic rand_step();
        logic       av, cv, ckl, rv;
        logic [3:0] aid, cid, rid;
        av  = ($urandom_range(0, 99) < 55);
        aid = pick_id(15);
        cv  = ($urandom_range(0, 99) < 45);
        cid = pick_id(85);
        ckl = ($urandom_range(0, 99) < 35);
        rv  = ($urandom_range(0, 99) < 45);
        rid = pick_id(85);
        // Keep same-cycle alloc clear of a kill aimed at another id.
        if (cv && ckl && av && aid != cid) av = 0;
        step(av, aid, cv, cid, ckl, rv, rid, pick_id(70), pick_id(70));
    endtask

    initial begin
        rst = 1'b1;
        alloc_valid = 0; commit_valid = 0; retire_valid = 0; commit_kill = 0;
        alloc_id = 0; commit_id = 0; retire_id = 0; lu_id = 0;
        m_err = '0;
        #1 rst = 1'b0;
        #2;
        check("por_count", 32'(count), 32'd0);
        check("por_empty", 32'(empty), 32'd1);
        check("por_ready", 32'(alloc_ready), 32'd1);
        check("por_err", 32'(err), 32'd0);
        #10 rst = 1'b1;

        // Fill, then an alloc while full.
        idle(0, 1);
        for (int i = 0; i < 8; i++) step(1, 4'(i), 0, 0, 0, 0, 0, 4'(i), 0);
        step(1, 8, 0, 0, 0, 0, 0, 8, 7);
        idle(8, 0);
        // Commit 3, kill 5, look them up, retire both.
        step(0, 0, 1, 3, 0, 0, 0, 3, 5);
        step(0, 0, 1, 5, 1, 0, 0, 3, 5);
        idle(3, 5);
        step(0, 0, 0, 0, 0, 1, 3, 3, 5);
        step(0, 0, 0, 0, 0, 1, 5, 3, 5);
        idle(3, 5);
        // Same-cycle alloc+commit, commit+retire.
        step(1, 9, 1, 9, 0, 0, 0, 9, 2);
        step(0, 0, 1, 2, 0, 1, 2, 9, 2);
        idle(9, 2);
        // Error pulses.
        step(1, 4, 0, 0, 0, 0, 0, 4, 6);
        step(0, 0, 1, 12, 0, 0, 0, 12, 4);
        step(0, 0, 0, 0, 0, 1, 6, 6, 12);
        idle(6, 4);
        idle(6, 4);
        // Kill of an older entry with younger ones outstanding.
        reset_mid_cycle();
        step(1, 1, 0, 0, 0, 0, 0, 1, 2);
        step(1, 2, 0, 0, 0, 0, 0, 1, 2);
        step(1, 3, 0, 0, 0, 0, 0, 2, 3);
        step(0, 0, 1, 1, 0, 0, 0, 2, 3);
        step(0, 0, 1, 2, 1, 0, 0, 2, 3);
        idle(2, 3);
        idle(1, 3);
        // Five live entries, reset mid-cycle, then alloc again.
        for (int i = 0; i < 2; i++) step(1, 4'(10 + i), 0, 0, 0, 0, 0, 0, 0);
        idle(1, 11);
        reset_mid_cycle();
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(0, 1);
        // Random traffic.
        for (int n = 0; n < 3000; n++) rand_step();
        idle(0, 0);
        repeat (3) @(posedge ck);
        #1;
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
